rns_unroll_seq: RTL

//  Multi-cycle sequencer that converts a 2-domain RNS operand (residues mod M1, M2) back to binary
//  via mixed-radix conversion: x = r1 + M1*(((r2 - r1) * M1_INV_M2) mod M2).

---
 rtl/rns_unroll_seq_if.sv | 37 +++
 rtl/rns_unroll_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rns_unroll_seq_if.sv
// EX-stage <-> UNRL sequencer signal bundle (master = EX stage, slave = sequencer).
// err_o and its modport entries exist only when RNS_UNRL_RANGE_CHK_EN is defined.
interface rns_unroll_seq_if #(
    parameter int unsigned OUT_WID = 16
);
    logic               start_i;
    logic [7:0]         res1_i;
    logic [7:0]         res2_i;
    logic [3:0]         dest_addr_i;
    logic               flush_i;
    logic               busy_o;
    logic               stall_o;
    logic               done_o;
    logic [OUT_WID-1:0] result_o;
    logic [3:0]         dest_addr_o;
`ifdef RNS_UNRL_RANGE_CHK_EN
    logic               err_o;

    modport master (
        output start_i, res1_i, res2_i, dest_addr_i, flush_i,
        input  busy_o, stall_o, done_o, result_o, dest_addr_o, err_o
    );
    modport slave (
        input  start_i, res1_i, res2_i, dest_addr_i, flush_i,
        output busy_o, stall_o, done_o, result_o, dest_addr_o, err_o
    );
`else
    modport master (
        output start_i, res1_i, res2_i, dest_addr_i, flush_i,
        input  busy_o, stall_o, done_o, result_o, dest_addr_o
    );
    modport slave (
        input  start_i, res1_i, res2_i, dest_addr_i, flush_i,
        output busy_o, stall_o, done_o, result_o, dest_addr_o
    );
`endif
endinterface

// File: rtl/rns_unroll_seq.sv
// Two-domain RNS -> binary mixed-radix converter for UNRL ops, fixed 18-cycle start-to-done.
// Define RNS_UNRL_RANGE_CHK_EN to flag out-of-range residues early via err_o.
module rns_unroll_seq #(
    parameter logic [8:0]  M1        = 9'd256,
    parameter logic [8:0]  M2        = 9'd129,
    parameter logic [7:0]  M1_INV_M2 = 8'd64,
    parameter int unsigned OUT_WID   = 16
) (
    input logic             clk,
    input logic             reset,
    rns_unroll_seq_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StSub, StMul, StScale, StDone} state_e;

    // With 2*M2 > 255 any 8-bit r1 reduces mod M2 with a single subtract.
    localparam bit SingleSub = ({1'b0, M2} << 1) > 10'd255;

    state_e             state_q, state_d;
    logic [7:0]         r1_q, r1_d, r2_q, r2_d;
    logic [3:0]         dest_q, dest_d, dest_out_q, dest_out_d;
    logic [8:0]         diff_q, diff_d, acc_q, acc_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [OUT_WID-1:0] scale_q, scale_d, result_q, result_d;
`ifdef RNS_UNRL_RANGE_CHK_EN
    logic               err_q, err_d;
`endif

    logic [8:0]         r1_mod;
    logic [9:0]         sub_raw, mul_sum, mul_red1;
    logic [7:0]         digit;
    logic [OUT_WID-1:0] scale_sum;
    logic               busy;

    always_comb begin
        if (SingleSub) begin
            r1_mod = ({1'b0, r1_q} >= M2) ? {1'b0, r1_q} - M2 : {1'b0, r1_q};
        end else begin
            r1_mod = {1'b0, r1_q} % M2;
        end
        sub_raw   = {2'b00, r2_q} - {1'b0, r1_mod};
        // MSB-first interleaved multiply: acc < M2 and diff < M2 keep the sum below 3*M2.
        mul_sum   = {acc_q, 1'b0} + (M1_INV_M2[~cnt_q] ? {1'b0, diff_q} : 10'd0);
        mul_red1  = (mul_sum >= {1'b0, M2}) ? mul_sum - {1'b0, M2} : mul_sum;
        digit     = acc_q[7:0];
        scale_sum = (scale_q << 1) + (digit[~cnt_q] ? OUT_WID'(M1) : '0);
    end

    always_comb begin
        state_d    = state_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        dest_d     = dest_q;
        dest_out_d = dest_out_q;
        diff_d     = diff_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        scale_d    = scale_q;
        result_d   = result_q;
`ifdef RNS_UNRL_RANGE_CHK_EN
        err_d      = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.flush_i) begin
                    r1_d    = bus.res1_i;
                    r2_d    = bus.res2_i;
                    dest_d  = bus.dest_addr_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    scale_d = '0;
`ifdef RNS_UNRL_RANGE_CHK_EN
                    err_d   = 1'b0;
`endif
                    state_d = StSub;
                end
            end
            StSub: begin
                diff_d  = sub_raw[9] ? 9'(sub_raw + {1'b0, M2}) : sub_raw[8:0];
                state_d = StMul;
`ifdef RNS_UNRL_RANGE_CHK_EN
                if (({1'b0, r1_q} >= M1) || ({1'b0, r2_q} >= M2)) begin
                    err_d      = 1'b1;
                    result_d   = '0;
                    dest_out_d = dest_q;
                    state_d    = StDone;
                end
`endif
            end
            StMul: begin
                acc_d = 9'((mul_red1 >= {1'b0, M2}) ? mul_red1 - {1'b0, M2} : mul_red1);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = StScale;
            end
            StScale: begin
                scale_d = scale_sum;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d   = scale_sum + OUT_WID'(r1_q);
                    dest_out_d = dest_q;
                    state_d    = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A flush during the conversion must leave the visible outputs untouched.
        if (bus.flush_i && (state_q inside {StSub, StMul, StScale})) begin
            state_d    = StIdle;
            result_d   = result_q;
            dest_out_d = dest_out_q;
`ifdef RNS_UNRL_RANGE_CHK_EN
            err_d      = err_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            r1_q       <= '0;
            r2_q       <= '0;
            dest_q     <= '0;
            dest_out_q <= '0;
            diff_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            scale_q    <= '0;
            result_q   <= '0;
`ifdef RNS_UNRL_RANGE_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            dest_q     <= dest_d;
            dest_out_q <= dest_out_d;
            diff_q     <= diff_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            scale_q    <= scale_d;
            result_q   <= result_d;
`ifdef RNS_UNRL_RANGE_CHK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign busy            = state_q inside {StSub, StMul, StScale};
    assign bus.busy_o      = busy;
    assign bus.stall_o     = busy | (bus.start_i & (state_q == StIdle));
    assign bus.done_o      = (state_q == StDone);
    assign bus.result_o    = result_q;
    assign bus.dest_addr_o = dest_out_q;
`ifdef RNS_UNRL_RANGE_CHK_EN
    assign bus.err_o       = err_q;
`endif
endmodule
